// File: rtl/wb_dest_sequencer_if.sv
// Bundle, register-file, segment and memory-write signals of the write-back destination sequencer.
// in_valid/in_ready and mem_req/mem_ack: a transfer happens on a rising edge where both are high;
// the producer holds its payload stable until then, and the sequencer never makes ready/request depend
// on valid/ack combinationally.
interface wb_dest_sequencer_if #(
   parameter int NUM_DEST   = 4,
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 32
);
   logic                           in_valid;
   logic                           in_ready;
   logic [NUM_DEST*DATA_WIDTH-1:0] res_data;
   logic [NUM_DEST*ADDR_WIDTH-1:0] dest_addr;
   logic [NUM_DEST*3-1:0]          dest_type;

   logic                           reg_we;
   logic [2:0]                     reg_waddr;
   logic [DATA_WIDTH-1:0]          reg_wdata;

   logic                           seg_we;
   logic [2:0]                     seg_waddr;
   logic [15:0]                    seg_wdata;

   logic                           mem_req;
   logic [ADDR_WIDTH-1:0]          mem_addr;
   logic [DATA_WIDTH-1:0]          mem_wdata;
   logic                           mem_ack;

   logic                           wb_done;
   logic                           bad_type;
   logic [1:0]                     dbg_state;

   modport slave (
      input  in_valid, res_data, dest_addr, dest_type, mem_ack,
      output in_ready, reg_we, reg_waddr, reg_wdata, seg_we, seg_waddr, seg_wdata,
             mem_req, mem_addr, mem_wdata, wb_done, bad_type, dbg_state
   );

   modport master (
      output in_valid, res_data, dest_addr, dest_type, mem_ack,
      input  in_ready, reg_we, reg_waddr, reg_wdata, seg_we, seg_waddr, seg_wdata,
             mem_req, mem_addr, mem_wdata, wb_done, bad_type, dbg_state
   );
endinterface

// File: rtl/wb_dest_sequencer.sv
// Write-back destination sequencer: latches a four-slot retired bundle and serialises its results,
// lowest slot first, onto the register-file, segment and handshaked memory write ports.
module wb_dest_sequencer #(
   parameter int NUM_DEST   = 4,
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 32
) (
   input logic              clk,
   input logic              clr,
   wb_dest_sequencer_if.slave bus
);
   localparam int SEL_W = $clog2(NUM_DEST);

   // Destination type encoding shared with the operand-select stage.
   localparam logic [2:0] T_REG = 3'b001;
   localparam logic [2:0] T_SEG = 3'b010;
   localparam logic [2:0] T_MEM = 3'b100;

   typedef enum logic [1:0] {
      IDLE     = 2'b00,
      DRAIN    = 2'b01,
      MEM_WAIT = 2'b10
   } state_t;

   state_t                state_q, state_d;
   logic [NUM_DEST-1:0]   pending_q, pending_d;
   logic [DATA_WIDTH-1:0] data_q [NUM_DEST];
   logic [ADDR_WIDTH-1:0] addr_q [NUM_DEST];
   logic [2:0]            type_q [NUM_DEST];
   logic                  bad_type_q;

   logic                  accept;
   logic [NUM_DEST-1:0]   in_pending;
   logic                  in_bad;

   logic [SEL_W-1:0]      sel;
   logic                  sel_any;
   logic [2:0]            sel_type;
   logic [DATA_WIDTH-1:0] sel_data;
   logic [ADDR_WIDTH-1:0] sel_addr;

   logic                  rdy_c;
   logic                  reg_we_c;
   logic                  seg_we_c;
   logic                  mem_req_c;
   logic                  done_c;

   // Classify incoming slot types; only one-hot types produce work.
   always_comb begin
      in_pending = '0;
      in_bad     = 1'b0;
      for (int i = 0; i < NUM_DEST; i++) begin
         case (bus.dest_type[3*i +: 3])
            T_REG, T_SEG, T_MEM: in_pending[i] = 1'b1;
            3'b000:              in_pending[i] = 1'b0;
            default:             in_bad        = 1'b1;
         endcase
      end
   end

   assign accept = (state_q == IDLE) && bus.in_valid;

   // Lowest-index pending slot goes first, so a later duplicate destination overwrites an earlier one.
   always_comb begin
      sel     = '0;
      sel_any = 1'b0;
      for (int i = NUM_DEST - 1; i >= 0; i--) begin
         if (pending_q[i]) begin
            sel     = SEL_W'(i);
            sel_any = 1'b1;
         end
      end
   end

   assign sel_type = type_q[sel];
   assign sel_data = data_q[sel];
   assign sel_addr = addr_q[sel];

   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      rdy_c     = 1'b0;
      reg_we_c  = 1'b0;
      seg_we_c  = 1'b0;
      mem_req_c = 1'b0;
      done_c    = 1'b0;
      case (state_q)
         IDLE: begin
            rdy_c = 1'b1;
            if (bus.in_valid) begin
               pending_d = in_pending;
               state_d   = DRAIN;
            end
         end
         DRAIN: begin
            if (!sel_any) begin
               done_c  = 1'b1;
               state_d = IDLE;
            end else begin
               case (sel_type)
                  T_REG: begin
                     reg_we_c       = 1'b1;
                     pending_d[sel] = 1'b0;
                  end
                  T_SEG: begin
                     seg_we_c       = 1'b1;
                     pending_d[sel] = 1'b0;
                  end
                  default: state_d = MEM_WAIT;
               endcase
            end
         end
         MEM_WAIT: begin
            mem_req_c = 1'b1;
            if (bus.mem_ack) begin
               pending_d[sel] = 1'b0;
               state_d        = DRAIN;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q    <= IDLE;
         pending_q  <= '0;
         bad_type_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         if (accept && in_bad) begin
            bad_type_q <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         for (int i = 0; i < NUM_DEST; i++) begin
            data_q[i] <= '0;
            addr_q[i] <= '0;
            type_q[i] <= '0;
         end
      end else if (accept) begin
         for (int i = 0; i < NUM_DEST; i++) begin
            data_q[i] <= bus.res_data[DATA_WIDTH*i +: DATA_WIDTH];
            addr_q[i] <= bus.dest_addr[ADDR_WIDTH*i +: ADDR_WIDTH];
            type_q[i] <= bus.dest_type[3*i +: 3];
         end
      end
   end

   // Address/data outputs read as zero whenever their strobe is low.
   assign bus.in_ready  = rdy_c;
   assign bus.reg_we    = reg_we_c;
   assign bus.reg_waddr = reg_we_c ? sel_addr[2:0] : 3'd0;
   assign bus.reg_wdata = reg_we_c ? sel_data : '0;
   assign bus.seg_we    = seg_we_c;
   assign bus.seg_waddr = seg_we_c ? sel_addr[2:0] : 3'd0;
   assign bus.seg_wdata = seg_we_c ? sel_data[15:0] : 16'd0;
   assign bus.mem_req   = mem_req_c;
   assign bus.mem_addr  = mem_req_c ? sel_addr : '0;
   assign bus.mem_wdata = mem_req_c ? sel_data : '0;
   assign bus.wb_done   = done_c;
   assign bus.bad_type  = bad_type_q;
   assign bus.dbg_state = state_q;
endmodule
